wormhole_port_allocator: RTL and testbench
==========================================

Name: wormhole_port_allocator

Overview:
- Allocates one router output port among five input ports (L, N, E, W, S) under wormhole switching.
- Grants the port to one header flit in round-robin order, then holds it until that packet's tail flit has been transferred.
- Drives the crossbar select and the per-input FIFO read pulses for that output.
- One instance sits per output port, between the flowcontrol ready signals and the xbar/output_buffer.

Parameters:
- LEN_W, 12, width of the packet-length field carried in the header flit (flits per packet, header and tail included).
- NPORT, 5, number of requesters; fixed order index 0=L, 1=N, 2=E, 3=W, 4=S.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req  in  NPORT  per-input request: input FIFO non-empty and routed (flowcontrol ready) to this output
- flit_type  in  3*NPORT  flit type at each FIFO head; encoding 3'b001 header, 3'b010 body, 3'b100 tail
- pkt_len  in  LEN_W*NPORT  length field of each head flit; valid only while that flit_type is header
- dcts  in  1  downstream clear-to-send for this output
- state  out  NPORT+1  one-hot registered state; bit0 IDLE, bit i+1 = input i owns the port
- sel  out  NPORT  xbar select, equal to state[NPORT:1]
- xfer  out  NPORT  combinational read/transfer pulse: sel & req & {NPORT{dcts}}
- busy  out  1  ~state[0]
- frame_err  out  1  sticky framing-error flag; cleared only by rst

Behaviour:
- Reset (rst=1 at a clk edge): state=6'b000001, sel=0, busy=0, frame_err=0, priority pointer=0 (L highest), flit counter=0. xfer is therefore 0.
- Reset mid-packet aborts the grant immediately. No flit is transferred in the reset cycle.

IDLE state:
- Candidates are inputs with req[i]=1 and flit_type[i]=header. Body or tail flits at a head are ignored while IDLE.
- Winner is the first candidate scanning ptr, ptr+1, … mod NPORT.
- Next cycle: state=one-hot(winner); counter loads eff_len-1.
- eff_len = pkt_len[winner], except values 0 and 1 are replaced by 2 and set frame_err.
- Grant latency is 1 cycle from header visible with req=1 to sel asserted. No flit moves in the IDLE cycle.

OWN_i state:
- A transfer occurs in any cycle with req[i] & dcts; xfer[i]=1 for exactly that cycle.
- The first transfer is the header. It does not decrement the counter; a flag records that the header has been sent.
- Each later transfer decrements the counter by 1.
- Release: if a transfer occurs with the counter at 1 and flit_type[i]=tail, next state is IDLE and ptr=(i+1) mod NPORT.
- Early tail: a tail transferred with counter>1 also releases and updates ptr, and sets frame_err.
- Missing tail: a non-tail flit transferred when the counter is at 1 sets frame_err and forces release after that transfer.
- dcts=0 or req[i]=0 stalls: no xfer, counter held, state held. There is no timeout.
- Other inputs' requests are ignored while a packet is in progress. No preemption.

Timing and arithmetic:
- Back-to-back packets: IDLE lasts exactly one cycle between the release and the next grant.
- A single requester gets consecutive grants (ptr skips to it).
- Counter is LEN_W bits, unsigned, and never underflows (release is forced at 1).
- Maximum packet length is 2^LEN_W-1 flits.
- At most one bit of xfer is high. state is always exactly one-hot; an illegal encoding returns to IDLE on the next edge.

Test Plan:
- Reset, then L presents header len=3 with dcts=1 and holds req: state 000001 → 000010 next cycle. xfer[0] high 3 cycles (header, body, tail), then IDLE one cycle; ptr=1.
- L and W present headers simultaneously with ptr=0: L is granted first. After L's tail, W is granted (state 010000); afterwards ptr=4.
- dcts dropped for 4 cycles mid-packet (len=4): xfer=0 during the stall, sel held, counter unchanged. Exactly 4 xfers in total, then IDLE.
- Header with pkt_len=1: frame_err=1, packet treated as 2 flits. Grant released after header+tail.
- Tail arrives after the header in a len=5 packet: release after the tail, frame_err=1. A pending S header is granted in the next IDLE→OWN cycle.
- rst asserted while OWN_E with counter=2: the next cycle has state=000001, xfer=0, frame_err=0, and ptr=0.

Source files
------------

// File: rtl/wormhole_port_allocator.sv
// Wormhole output-port allocator: round-robin grant on header flits, holds the
// port until the packet's tail has been transferred, drives xbar select and FIFO reads.
module wormhole_port_allocator #(
  parameter int LEN_W = 12,
  parameter int NPORT = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NPORT-1:0]       req,
  input  logic [3*NPORT-1:0]     flit_type,
  input  logic [LEN_W*NPORT-1:0] pkt_len,
  input  logic                   dcts,
  output logic [NPORT:0]         state,
  output logic [NPORT-1:0]       sel,
  output logic [NPORT-1:0]       xfer,
  output logic                   busy,
  output logic                   frame_err
);

  localparam int PTR_W = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam logic [NPORT:0] IDLE_ST = {{NPORT{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    FT_HEAD = 3'b001,
    FT_BODY = 3'b010,
    FT_TAIL = 3'b100
  } flit_t;

  logic [PTR_W-1:0] ptr;
  logic [LEN_W-1:0] cnt;
  logic             hdr_sent;
  logic             legal;
  logic             win_found;
  int unsigned      win_idx;
  int unsigned      own_idx;
  int unsigned      nxt_ptr;
  logic [LEN_W-1:0] win_len;
  logic             own_tail;
  logic             do_xfer;

  assign legal = $onehot(state);
  assign sel   = state[NPORT:1];
  assign busy  = ~state[0];
  // Gated by rst so an aborted grant never pops a FIFO in the reset cycle.
  assign xfer    = (legal && !rst) ? (sel & req & {NPORT{dcts}}) : '0;
  assign do_xfer = |xfer;

  always_comb begin
    int unsigned idx;
    win_found = 1'b0;
    win_idx   = 0;
    own_idx   = 0;
    for (int unsigned k = 0; k < NPORT; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= NPORT) idx = idx - NPORT;
      if (!win_found && req[idx] && (flit_type[3*idx +: 3] == FT_HEAD)) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
    for (int unsigned i = 0; i < NPORT; i++) begin
      if (state[i+1]) own_idx = i;
    end
    win_len  = pkt_len[LEN_W*win_idx +: LEN_W];
    own_tail = (flit_type[3*own_idx +: 3] == FT_TAIL);
    nxt_ptr  = (own_idx == NPORT - 1) ? 0 : own_idx + 1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE_ST;
      ptr       <= '0;
      cnt       <= '0;
      hdr_sent  <= 1'b0;
      frame_err <= 1'b0;
    end else if (!legal) begin
      state    <= IDLE_ST;
      cnt      <= '0;
      hdr_sent <= 1'b0;
    end else if (state[0]) begin
      if (win_found) begin
        state    <= IDLE_ST << (win_idx + 1);
        hdr_sent <= 1'b0;
        if (win_len < LEN_W'(2)) begin
          cnt       <= LEN_W'(1);
          frame_err <= 1'b1;
        end else begin
          cnt <= win_len - 1'b1;
        end
      end
    end else if (do_xfer) begin
      if (!hdr_sent) begin
        hdr_sent <= 1'b1;
      end else if ((cnt == LEN_W'(1)) || own_tail) begin
        // Clean release only when the tail lands exactly at count 1.
        if ((cnt == LEN_W'(1)) != own_tail) frame_err <= 1'b1;
        state    <= IDLE_ST;
        ptr      <= PTR_W'(nxt_ptr);
        cnt      <= '0;
        hdr_sent <= 1'b0;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wormhole_port_allocator.sv
// Directed-vector bench for wormhole_port_allocator: grants, round-robin pointer,
// stalls, framing errors and mid-packet reset.
module tb_wormhole_port_allocator;

  localparam int LEN_W = 12;
  localparam int NPORT = 5;
  localparam logic [2:0] HDR  = 3'b001;
  localparam logic [2:0] BODY = 3'b010;
  localparam logic [2:0] TAIL = 3'b100;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NPORT-1:0]       req;
  logic [3*NPORT-1:0]     flit_type;
  logic [LEN_W*NPORT-1:0] pkt_len;
  logic                   dcts;
  logic [NPORT:0]         state;
  logic [NPORT-1:0]       sel;
  logic [NPORT-1:0]       xfer;
  logic                   busy;
  logic                   frame_err;

  int errors = 0;
  int checks = 0;

  wormhole_port_allocator #(.LEN_W(LEN_W), .NPORT(NPORT)) dut (
    .clk(clk), .rst(rst), .req(req), .flit_type(flit_type), .pkt_len(pkt_len),
    .dcts(dcts), .state(state), .sel(sel), .xfer(xfer), .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int p, input logic [2:0] ft, input logic [LEN_W-1:0] len);
    req[p] = 1'b1;
    flit_type[3*p +: 3] = ft;
    pkt_len[LEN_W*p +: LEN_W] = len;
  endtask

  task automatic drop(input int p);
    req[p] = 1'b0;
    flit_type[3*p +: 3] = 3'b000;
    pkt_len[LEN_W*p +: LEN_W] = '0;
  endtask

  task automatic clr_all();
    req = '0;
    flit_type = '0;
    pkt_len = '0;
    dcts = 1'b1;
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    clr_all();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clr_all();
    step();
    step();
    #1;
    checks++; if (state !== 6'b000001) begin errors++; $display("FAIL reset_state got=%b exp=%b", state, 6'b000001); end
    checks++; if (sel !== 5'b00000) begin errors++; $display("FAIL reset_sel got=%b exp=%b", sel, 5'b00000); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    checks++; if (xfer !== 5'b00000) begin errors++; $display("FAIL reset_xfer got=%b exp=%b", xfer, 5'b00000); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    put(0, HDR, 3);
    #1;
    checks++; if (state !== 6'b000001) begin errors++; $display("FAIL single_idle got=%b exp=%b", state, 6'b000001); end
    checks++; if (xfer !== 5'b00000) begin errors++; $display("FAIL single_idle_xfer got=%b exp=%b", xfer, 5'b00000); end
    step(); #1;
    checks++; if (state !== 6'b000010) begin errors++; $display("FAIL single_grant got=%b exp=%b", state, 6'b000010); end
    checks++; if (sel !== 5'b00001) begin errors++; $display("FAIL single_sel got=%b exp=%b", sel, 5'b00001); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b exp=1", busy); end
    checks++; if (xfer !== 5'b00001) begin errors++; $display("FAIL single_hdr_xfer got=%b exp=%b", xfer, 5'b00001); end
    step(); put(0, BODY, 0); #1;
    checks++; if (xfer !== 5'b00001) begin errors++; $display("FAIL single_body_xfer got=%b exp=%b", xfer, 5'b00001); end
    step(); put(0, TAIL, 0); #1;
    checks++; if (xfer !== 5'b00001) begin errors++; $display("FAIL single_tail_xfer got=%b exp=%b", xfer, 5'b00001); end
    checks++; if (state !== 6'b000010) begin errors++; $display("FAIL single_hold got=%b exp=%b", state, 6'b000010); end
    step(); put(0, HDR, 2); put(1, HDR, 2); #1;
    checks++; if (state !== 6'b000001) begin errors++; $display("FAIL single_release got=%b exp=%b", state, 6'b000001); end
    checks++; if (xfer !== 5'b00000) begin errors++; $display("FAIL single_release_xfer got=%b exp=%b", xfer, 5'b00000); end
    step(); #1;
    checks++; if (state !== 6'b000100) begin errors++; $display("FAIL single_ptr1 got=%b exp=%b", state, 6'b000100); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL single_frame_err got=%b exp=0", frame_err); end
    rst_pulse();
  endtask

  task automatic test_two();
    put(0, HDR, 2); put(3, HDR, 2);
    step(); #1;
    checks++; if (state !== 6'b000010) begin errors++; $display("FAIL two_first got=%b exp=%b", state, 6'b000010); end
    checks++; if (xfer !== 5'b00001) begin errors++; $display("FAIL two_first_xfer got=%b exp=%b", xfer, 5'b00001); end
    step(); put(0, TAIL, 0); #1;
    checks++; if (xfer !== 5'b00001) begin errors++; $display("FAIL two_no_preempt got=%b exp=%b", xfer, 5'b00001); end
    step(); drop(0); #1;
    checks++; if (state !== 6'b000001) begin errors++; $display("FAIL two_gap got=%b exp=%b", state, 6'b000001); end
    step(); #1;
    checks++; if (state !== 6'b010000) begin errors++; $display("FAIL two_second got=%b exp=%b", state, 6'b010000); end
    checks++; if (xfer !== 5'b01000) begin errors++; $display("FAIL two_second_xfer got=%b exp=%b", xfer, 5'b01000); end
    step(); put(3, TAIL, 0); #1;
    step(); drop(3); put(0, HDR, 2); put(3, HDR, 2); put(4, HDR, 2); #1;
    checks++; if (state !== 6'b000001) begin errors++; $display("FAIL two_release got=%b exp=%b", state, 6'b000001); end
    step(); #1;
    checks++; if (state !== 6'b100000) begin errors++; $display("FAIL two_ptr4 got=%b exp=%b", state, 6'b100000); end
    rst_pulse();
  endtask

  task automatic test_stall();
    put(2, HDR, 4);
    step(); #1;
    checks++; if (xfer !== 5'b00100) begin errors++; $display("FAIL stall_hdr got=%b exp=%b", xfer, 5'b00100); end
    step(); put(2, BODY, 0); #1;
    checks++; if (xfer !== 5'b00100) begin errors++; $display("FAIL stall_body1 got=%b exp=%b", xfer, 5'b00100); end
    step(); dcts = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (xfer !== 5'b00000) begin errors++; $display("FAIL stall_xfer cyc=%0d got=%b exp=%b", i, xfer, 5'b00000); end
      checks++; if (sel !== 5'b00100) begin errors++; $display("FAIL stall_sel cyc=%0d got=%b exp=%b", i, sel, 5'b00100); end
      step();
    end
    dcts = 1'b1; #1;
    checks++; if (xfer !== 5'b00100) begin errors++; $display("FAIL stall_body2 got=%b exp=%b", xfer, 5'b00100); end
    step(); put(2, TAIL, 0); #1;
    checks++; if (xfer !== 5'b00100) begin errors++; $display("FAIL stall_tail got=%b exp=%b", xfer, 5'b00100); end
    step(); drop(2); #1;
    checks++; if (state !== 6'b000001) begin errors++; $display("FAIL stall_release got=%b exp=%b", state, 6'b000001); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL stall_frame_err got=%b exp=0", frame_err); end
  endtask

  task automatic test_len1();
    rst_pulse();
    put(1, HDR, 1);
    step(); #1;
    checks++; if (state !== 6'b000100) begin errors++; $display("FAIL len1_grant got=%b exp=%b", state, 6'b000100); end
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL len1_frame_err got=%b exp=1", frame_err); end
    step(); put(1, TAIL, 0); #1;
    checks++; if (xfer !== 5'b00010) begin errors++; $display("FAIL len1_tail got=%b exp=%b", xfer, 5'b00010); end
    step(); drop(1); #1;
    checks++; if (state !== 6'b000001) begin errors++; $display("FAIL len1_release got=%b exp=%b", state, 6'b000001); end
  endtask

  task automatic test_missing_tail();
    rst_pulse();
    put(0, HDR, 2);
    step();
    step(); put(0, BODY, 0); #1;
    checks++; if (xfer !== 5'b00001) begin errors++; $display("FAIL missing_tail_xfer got=%b exp=%b", xfer, 5'b00001); end
    step(); drop(0); #1;
    checks++; if (state !== 6'b000001) begin errors++; $display("FAIL missing_tail_release got=%b exp=%b", state, 6'b000001); end
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL missing_tail_frame_err got=%b exp=1", frame_err); end
  endtask

  task automatic test_early_tail();
    rst_pulse();
    put(3, HDR, 5); put(4, HDR, 2);
    step(); #1;
    checks++; if (state !== 6'b010000) begin errors++; $display("FAIL early_grant got=%b exp=%b", state, 6'b010000); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL early_pre_err got=%b exp=0", frame_err); end
    step(); put(3, TAIL, 0); #1;
    checks++; if (xfer !== 5'b01000) begin errors++; $display("FAIL early_tail_xfer got=%b exp=%b", xfer, 5'b01000); end
    step(); drop(3); #1;
    checks++; if (state !== 6'b000001) begin errors++; $display("FAIL early_release got=%b exp=%b", state, 6'b000001); end
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL early_frame_err got=%b exp=1", frame_err); end
    step(); #1;
    checks++; if (state !== 6'b100000) begin errors++; $display("FAIL early_next_grant got=%b exp=%b", state, 6'b100000); end
    checks++; if (xfer !== 5'b10000) begin errors++; $display("FAIL early_next_xfer got=%b exp=%b", xfer, 5'b10000); end
  endtask

  task automatic test_reset_mid();
    step(); put(4, TAIL, 0);
    step(); drop(4); put(1, HDR, 2);
    step();
    step(); put(1, TAIL, 0);
    step(); drop(1); put(2, HDR, 4);
    step();
    step(); put(2, BODY, 0);
    step(); #1;
    checks++; if (state !== 6'b001000) begin errors++; $display("FAIL rmid_own got=%b exp=%b", state, 6'b001000); end
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL rmid_pre_err got=%b exp=1", frame_err); end
    rst = 1'b1; #1;
    checks++; if (xfer !== 5'b00000) begin errors++; $display("FAIL rmid_rst_cycle_xfer got=%b exp=%b", xfer, 5'b00000); end
    step(); rst = 1'b0; #1;
    checks++; if (state !== 6'b000001) begin errors++; $display("FAIL rmid_state got=%b exp=%b", state, 6'b000001); end
    checks++; if (xfer !== 5'b00000) begin errors++; $display("FAIL rmid_xfer got=%b exp=%b", xfer, 5'b00000); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rmid_frame_err got=%b exp=0", frame_err); end
    drop(2); put(1, HDR, 2); put(3, HDR, 2);
    step(); #1;
    checks++; if (state !== 6'b000100) begin errors++; $display("FAIL rmid_ptr0 got=%b exp=%b", state, 6'b000100); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_two();
    test_stall();
    test_len1();
    test_missing_tail();
    test_early_tail();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
